draw_line_stream: RTL and testbench
===================================

Name: draw_line_stream

Overview:
Parametrised Bresenham line rasteriser. Successor to the fixed 16-bit DrawLine generator.
- Accepts two endpoints on a start pulse.
- Emits every pixel of the line, one per valid/ready handshake, replacing the old get_pixel strobe.
- Adds configurable coordinate width, a per-pixel dash-pattern flag, an explicit last-pixel marker and a synchronous abort.
- Sits between the command decoder and the framebuffer write arbiter.

Parameters:
COORD_W, 16, width of each unsigned coordinate
DASH_W, 8, length of the repeating dash pattern in pixels

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a line; sampled only in IDLE
abort  in  1  synchronous cancel of the line in progress
x1  in  COORD_W  start x
y1  in  COORD_W  start y
x2  in  COORD_W  end x
y2  in  COORD_W  end y
dash_pattern  in  DASH_W  on/off pattern; bit 0 applies to the first pixel; sampled with start
px_ready  in  1  downstream accepts the pixel
px_valid  out  1  x_o/y_o hold a valid pixel
x_o  out  COORD_W  pixel x
y_o  out  COORD_W  pixel y
px_on  out  1  dash bit for the current pixel
px_last  out  1  current pixel is the endpoint (x2,y2)
busy  out  1  high in any state other than IDLE
line_complete  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0. Internal registers 0.
- States:
  - IDLE -> SETUP on start.
  - SETUP -> EMIT unconditionally.
  - EMIT -> DONE on a handshake while px_last=1.
  - DONE -> IDLE unconditionally.
  - abort in SETUP or EMIT -> IDLE. No line_complete. Outputs cleared the next cycle.
- Start and latency:
  - start in IDLE latches x1..y2 and dash_pattern. start outside IDLE is ignored.
  - start sampled at edge N gives px_valid=1 from edge N+2. This first pixel is (x1,y1).
- SETUP computes, signed width COORD_W+2:
  - dx=|x2-x1|
  - dy=-|y2-y1|
  - sx=(x1<x2)?+1:-1
  - sy=(y1<y2)?+1:-1
  - err=dx+dy
- Stepping:
  - Only on handshake (px_valid&&px_ready) with px_last=0.
  - e2=2*err, width COORD_W+3.
  - If e2>=dy: err+=dy, x+=sx.
  - If e2<=dx: err+=dx, y+=sy.
  - Both conditions may apply in the same cycle (diagonal step).
  - The new pixel is presented the cycle after the handshake, so throughput is 1 pixel/cycle with px_ready held high.
- Backpressure: while px_valid=1 and px_ready=0, x_o, y_o, px_on and px_last hold stable.
- Pixel count: max(|x2-x1|,|y2-y1|)+1. Degenerate line (x1==x2, y1==y2) emits exactly one pixel with px_last=1.
- px_last is combinational on the registered current point: (x==x2_l)&&(y==y2_l).
- Dash:
  - Index counter runs 0..DASH_W-1 and resets to 0 at each start.
  - It advances on each handshake and wraps from DASH_W-1 to 0.
  - px_on = dash_l[idx].
  - All pixels are emitted regardless of px_on.
- line_complete is high for exactly the DONE cycle. px_valid=0 in DONE.
- Coordinates never wrap: all traversed points lie between the endpoints.
- abort and a handshake in the same cycle: abort wins, and line_complete does not pulse.
- Reset mid-line: immediate return to IDLE with all outputs 0.

Decomposition:
- Package draw_line_pkg holds:
  - state enum (IDLE, SETUP, EMIT, DONE)
  - default COORD_W/DASH_W localparams
  - helper function abs_diff
- No sub-module. The datapath and FSM belong in one module; the Bresenham step stays inline.

Test Plan:
- (100,90)->(50,100), px_ready=1 -> 51 pixels, first (100,90), last (50,100) with px_last=1, line_complete one cycle after, busy low next cycle.
- (10,50)->(20,50), dash_pattern=8'b00001111 -> 11 pixels, y=50, x 10..20, px_on sequence 1,1,1,1,0,0,0,0,1,1,1.
- (10,5)->(10,5) -> single pixel (10,5) with px_last=1 on the first valid, then line_complete pulse.
- (30,10)->(20,20), px_ready toggled 1/0 every cycle -> 11 diagonal pixels (30,10),(29,11)..(20,20), outputs stable while px_ready=0, no pixel duplicated or dropped.
- (90,100)->(100,50), abort after the 5th handshake -> returns to IDLE next cycle, px_valid=0, no line_complete; a new start is then accepted normally.
- Reset asserted mid-line with COORD_W=12 instance -> all outputs 0 asynchronously; start issued on the first cycle in IDLE with start also pulsed during busy -> the busy-time start is ignored.

Source files
------------

// File: rtl/draw_line_pkg.sv
// Shared types and helpers for the Bresenham line streamer: FSM states,
// default geometry and the unsigned distance helper used by SETUP.
package draw_line_pkg;

  localparam int DEF_COORD_W = 16;
  localparam int DEF_DASH_W  = 8;
  localparam int ABS_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/draw_line_stream_if.sv
// Pixel stream from the rasteriser to the framebuffer write arbiter:
// one pixel per px_valid/px_ready handshake.
interface draw_line_stream_if #(
  parameter int COORD_W = 16
);
  logic               px_valid;
  logic               px_ready;
  logic [COORD_W-1:0] x_o;
  logic [COORD_W-1:0] y_o;
  logic               px_on;
  logic               px_last;

  modport master (
    output px_valid, x_o, y_o, px_on, px_last,
    input  px_ready
  );

  modport slave (
    input  px_valid, x_o, y_o, px_on, px_last,
    output px_ready
  );
endinterface

// File: rtl/draw_line_stream.sv
// Bresenham line rasteriser: latches two endpoints on start and streams every
// pixel of the line with a dash flag and an endpoint marker.
module draw_line_stream
  import draw_line_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int DASH_W  = DEF_DASH_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic [DASH_W-1:0]  dash_pattern,
  draw_line_stream_if.master px,
  output logic               busy,
  output logic               line_complete
);

  localparam int SW    = COORD_W + 2;
  localparam int EW    = COORD_W + 3;
  localparam int IDX_W = (DASH_W > 1) ? $clog2(DASH_W) : 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [COORD_W-1:0]    r_x;
  logic [COORD_W-1:0]    r_y;
  logic [COORD_W-1:0]    r_x2;
  logic [COORD_W-1:0]    r_y2;
  logic signed [SW-1:0]  r_dx;
  logic signed [SW-1:0]  r_dy;
  logic signed [SW-1:0]  r_err;
  logic                  r_sx_neg;
  logic                  r_sy_neg;
  logic [DASH_W-1:0]     r_dash;
  logic [IDX_W-1:0]      r_idx;

  logic                  w_emit;
  logic                  w_last;
  logic                  w_hs;
  logic                  w_step_x;
  logic                  w_step_y;
  logic signed [EW-1:0]  w_e2;
  logic signed [SW-1:0]  w_err_next;
  logic signed [SW-1:0]  w_dx_abs;
  logic signed [SW-1:0]  w_dy_abs;

  assign w_emit   = (r_state == EMIT);
  assign w_last   = (r_x == r_x2) && (r_y == r_y2);
  // abort takes priority over a coincident handshake
  assign w_hs     = w_emit && px.px_ready && !abort;

  assign w_dx_abs = SW'(abs_diff(ABS_W'(r_x), ABS_W'(r_x2)));
  assign w_dy_abs = SW'(abs_diff(ABS_W'(r_y), ABS_W'(r_y2)));

  assign w_e2       = {r_err, 1'b0};
  assign w_step_x   = w_e2 >= $signed({r_dy[SW-1], r_dy});
  assign w_step_y   = w_e2 <= $signed({r_dx[SW-1], r_dx});
  assign w_err_next = r_err + (w_step_x ? r_dy : SW'(0)) + (w_step_y ? r_dx : SW'(0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = SETUP;
      SETUP:   w_state_next = abort ? IDLE : EMIT;
      EMIT: begin
        if (abort)                       w_state_next = IDLE;
        else if (px.px_ready && w_last)  w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_x2     <= '0;
      r_y2     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_dash   <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x    <= x1;
            r_y    <= y1;
            r_x2   <= x2;
            r_y2   <= y2;
            r_dash <= dash_pattern;
            r_idx  <= '0;
          end
        end
        SETUP: begin
          r_dx     <= w_dx_abs;
          r_dy     <= -w_dy_abs;
          r_err    <= w_dx_abs - w_dy_abs;
          r_sx_neg <= !(r_x < r_x2);
          r_sy_neg <= !(r_y < r_y2);
        end
        EMIT: begin
          if (w_hs) begin
            r_idx <= (r_idx == IDX_W'(DASH_W - 1)) ? '0 : r_idx + 1'b1;
            if (!w_last) begin
              r_err <= w_err_next;
              if (w_step_x) r_x <= r_sx_neg ? r_x - 1'b1 : r_x + 1'b1;
              if (w_step_y) r_y <= r_sy_neg ? r_y - 1'b1 : r_y + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel outputs are gated so they read zero whenever no pixel is offered
  assign px.px_valid  = w_emit;
  assign px.x_o       = w_emit ? r_x : '0;
  assign px.y_o       = w_emit ? r_y : '0;
  assign px.px_on     = w_emit && r_dash[r_idx];
  assign px.px_last   = w_emit && w_last;
  assign busy          = (r_state != IDLE);
  assign line_complete = (r_state == DONE);

endmodule

// File: tb/tb_draw_line_stream.sv
// Scoreboard bench for draw_line_stream: directed lines with hand-derived
// pixel sequences, backpressure, abort and asynchronous reset.
module tb_draw_line_stream;
  import draw_line_pkg::*;

  typedef struct {
    int x;
    int y;
    bit on;
    bit last;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 16-bit instance
  logic        rst_n, start, abort, busy, lc;
  logic [15:0] x1, y1, x2, y2;
  logic [7:0]  dash;
  draw_line_stream_if #(.COORD_W(16)) pif ();

  draw_line_stream #(.COORD_W(16), .DASH_W(8)) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .dash_pattern(dash),
    .px(pif.master), .busy(busy), .line_complete(lc)
  );

  // 12-bit instance
  logic        rst12_n, start12, abort12, busy12, lc12;
  logic [11:0] x1_12, y1_12, x2_12, y2_12;
  logic [7:0]  dash12;
  draw_line_stream_if #(.COORD_W(12)) pif12 ();

  draw_line_stream #(.COORD_W(12), .DASH_W(8)) dut12 (
    .clk(clk), .reset(rst12_n), .start(start12), .abort(abort12),
    .x1(x1_12), .y1(y1_12), .x2(x2_12), .y2(y2_12), .dash_pattern(dash12),
    .px(pif12.master), .busy(busy12), .line_complete(lc12)
  );

  pix_t q[$];
  pix_t q12[$];
  int   n_hs = 0;
  int   lc_cnt = 0;
  int   n12_hs = 0;
  int   lc12_cnt = 0;
  bit   mon12_en = 1'b0;

  function automatic pix_t mk(int x, int y, bit on, bit last);
    pix_t p;
    p.x = x; p.y = y; p.on = on; p.last = last;
    return p;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the 16-bit instance: pops on every handshake
  initial begin
    bit   lc_due = 1'b0;
    bit   busy_due = 1'b0;
    bit   stall_prev = 1'b0;
    pix_t prev;
    pix_t e;
    forever begin
      @(negedge clk);
      if (busy_due) check("busy_after_done", int'(busy), 0);
      busy_due = lc_due;
      if (lc || lc_due) begin
        check("line_complete", int'(lc), int'(lc_due));
        check("valid_in_done", int'(pif.px_valid), 0);
      end
      if (lc) lc_cnt++;
      lc_due = 1'b0;
      if (stall_prev && pif.px_valid) begin
        check("stall_x", int'(pif.x_o), prev.x);
        check("stall_y", int'(pif.y_o), prev.y);
        check("stall_on", int'(pif.px_on), int'(prev.on));
        check("stall_last", int'(pif.px_last), int'(prev.last));
      end
      stall_prev = pif.px_valid && !pif.px_ready;
      prev = mk(int'(pif.x_o), int'(pif.y_o), pif.px_on, pif.px_last);
      if (pif.px_valid && pif.px_ready) begin
        n_hs++;
        if (q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = q.pop_front();
          check("x_o", int'(pif.x_o), e.x);
          check("y_o", int'(pif.y_o), e.y);
          check("px_on", int'(pif.px_on), int'(e.on));
          check("px_last", int'(pif.px_last), int'(e.last));
        end
        lc_due = pif.px_last;
      end
    end
  end

  // Monitor for the 12-bit instance
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (lc12) lc12_cnt++;
      if (mon12_en && pif12.px_valid && pif12.px_ready) begin
        n12_hs++;
        if (q12.size() == 0) begin
          check("unexpected_pixel12", 1, 0);
        end else begin
          e = q12.pop_front();
          check("x12", int'(pif12.x_o), e.x);
          check("y12", int'(pif12.y_o), e.y);
          check("on12", int'(pif12.px_on), int'(e.on));
          check("last12", int'(pif12.px_last), int'(e.last));
        end
      end
    end
  end

  task automatic start_line(int ax, int ay, int bx, int by, logic [7:0] pat);
    @(posedge clk); #1;
    x1 = 16'(ax); y1 = 16'(ay); x2 = 16'(bx); y2 = 16'(by);
    dash = pat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("setup_busy", int'(busy), 1);
    check("setup_no_valid", int'(pif.px_valid), 0);
    @(posedge clk); #1;
    check("first_valid_latency", int'(pif.px_valid), 1);
  endtask

  task automatic run_line(int ax, int ay, int bx, int by, logic [7:0] pat, bit toggle);
    int lc0;
    int t;
    lc0 = lc_cnt;
    t = 0;
    start_line(ax, ay, bx, by, pat);
    while (lc_cnt == lc0 && t < 500) begin
      if (toggle) pif.px_ready = ~pif.px_ready;
      @(posedge clk); #1;
      t++;
    end
    pif.px_ready = 1'b1;
    if (t >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL line_timeout: got no line_complete, expected one within 500 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    check("lc_once", lc_cnt - lc0, 1);
  endtask

  initial begin
    int t;
    int base;
    int lc0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; dash = '0;
    pif.px_ready = 1'b1;
    rst12_n = 1'b0; start12 = 1'b0; abort12 = 1'b0;
    x1_12 = '0; y1_12 = '0; x2_12 = '0; y2_12 = '0; dash12 = '0;
    pif12.px_ready = 1'b1;
    #1;
    check("rst_valid", int'(pif.px_valid), 0);
    check("rst_x", int'(pif.x_o), 0);
    check("rst_y", int'(pif.y_o), 0);
    check("rst_on", int'(pif.px_on), 0);
    check("rst_last", int'(pif.px_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lc", int'(lc), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // x-major, leftward: y steps every 5th pixel starting at k=3
    for (int k = 0; k <= 50; k++) q.push_back(mk(100 - k, 90 + (k + 2) / 5, 1'b1, k == 50));
    run_line(100, 90, 50, 100, 8'hFF, 1'b0);

    // horizontal with dash 00001111
    for (int k = 0; k <= 10; k++) q.push_back(mk(10 + k, 50, (k % 8) < 4, k == 10));
    run_line(10, 50, 20, 50, 8'h0F, 1'b0);

    // degenerate single point
    q.push_back(mk(10, 5, 1'b1, 1'b1));
    run_line(10, 5, 10, 5, 8'h01, 1'b0);

    // pure diagonal under toggling backpressure, dash 01010101
    for (int k = 0; k <= 10; k++) q.push_back(mk(30 - k, 10 + k, (k % 2) == 0, k == 10));
    run_line(30, 10, 20, 20, 8'h55, 1'b1);

    // y-major line aborted after the 5th handshake, dash 10100101
    q.push_back(mk(90, 100, 1'b1, 1'b0));
    q.push_back(mk(90,  99, 1'b0, 1'b0));
    q.push_back(mk(90,  98, 1'b1, 1'b0));
    q.push_back(mk(91,  97, 1'b0, 1'b0));
    q.push_back(mk(91,  96, 1'b0, 1'b0));
    base = n_hs;
    lc0 = lc_cnt;
    start_line(90, 100, 100, 50, 8'hA5);
    t = 0;
    while (n_hs < base + 5 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL abort_wait: got %0d handshakes, expected 5", n_hs - base);
    end
    pif.px_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    pif.px_ready = 1'b1;
    check("abort_valid", int'(pif.px_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_x", int'(pif.x_o), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_lc", lc_cnt - lc0, 0);
    check("abort_queue", q.size(), 0);

    // restart after abort: (1,1)->(3,2), dash 00000110
    q.push_back(mk(1, 1, 1'b0, 1'b0));
    q.push_back(mk(2, 2, 1'b1, 1'b0));
    q.push_back(mk(3, 2, 1'b1, 1'b1));
    run_line(1, 1, 3, 2, 8'h06, 1'b0);

    // 12-bit instance: asynchronous reset mid-line
    @(posedge clk); #1;
    rst12_n = 1'b1;
    @(posedge clk); #1;
    x1_12 = 12'd0; y1_12 = 12'd0; x2_12 = 12'd100; y2_12 = 12'd0;
    dash12 = 8'hFF; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_valid12", int'(pif12.px_valid), 1);
    #1;
    rst12_n = 1'b0;
    #1;
    check("async_valid12", int'(pif12.px_valid), 0);
    check("async_x12", int'(pif12.x_o), 0);
    check("async_y12", int'(pif12.y_o), 0);
    check("async_on12", int'(pif12.px_on), 0);
    check("async_last12", int'(pif12.px_last), 0);
    check("async_busy12", int'(busy12), 0);
    check("async_lc12", int'(lc12), 0);

    // first IDLE cycle start, then a start while busy that must be ignored
    @(posedge clk); #1;
    rst12_n = 1'b1;
    mon12_en = 1'b1;
    lc0 = lc12_cnt;
    q12.push_back(mk(5, 5, 1'b0, 1'b0));
    q12.push_back(mk(6, 5, 1'b1, 1'b0));
    q12.push_back(mk(7, 5, 1'b0, 1'b0));
    q12.push_back(mk(8, 5, 1'b1, 1'b1));
    x1_12 = 12'd5; y1_12 = 12'd5; x2_12 = 12'd8; y2_12 = 12'd5;
    dash12 = 8'h0A; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    @(posedge clk); #1;
    x1_12 = 12'd0; y1_12 = 12'd0; x2_12 = 12'd1; y2_12 = 12'd1;
    dash12 = 8'hFF; start12 = 1'b1;
    check("busy12_at_restart", int'(busy12), 1);
    @(posedge clk); #1;
    start12 = 1'b0;
    t = 0;
    while (lc12_cnt == lc0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL line12_timeout: got no line_complete, expected one within 100 cycles");
    end
    repeat (4) @(posedge clk);
    #1;
    check("q12_drained", q12.size(), 0);
    check("hs12_count", n12_hs, 4);
    check("lc12_once", lc12_cnt - lc0, 1);
    check("busy12_idle", int'(busy12), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
